// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: states, field positions and configuration sanity check
// shared by the frame write scheduler and its burst buffer.
package frame_sched_pkg;
  localparam int MARKER_BIT = 16;
  localparam int PIX_W = 16;
  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_WAIT_SYNC,
    S_FILL,
    S_CMD,
    S_DATA,
    S_COMPLETE,
    S_DRAIN
  } state_e;
  function automatic bit cfg_ok(int burst_len, int frame_words, int addr_width, int buf_stride);
    return burst_len >= 4 && burst_len <= 64 && (burst_len & (burst_len - 1)) == 0
        && frame_words % burst_len == 0
        && longint'(buf_stride) + longint'(frame_words) <= (longint'(1) << addr_width);
  endfunction
endpackage

// File: rtl/frame_write_scheduler_burst_buffer.sv
// burst_buffer: one burst of pixels, filled in arrival order and drained by a
// read index that the scheduler advances on each accepted data beat.
module burst_buffer
  import frame_sched_pkg::*;
#(
  parameter int  BURST_LEN = 16,
  localparam int CW        = $clog2(BURST_LEN + 1),
  localparam int IW        = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_adv,
  output logic [CW-1:0]    fill_cnt,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_last
);
  logic [PIX_W-1:0] mem_q [BURST_LEN];
  logic [PIX_W-1:0] mem_d [BURST_LEN];
  logic [CW-1:0]    fill_q, fill_d;
  logic [IW-1:0]    idx_q, idx_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[fill_q[IW-1:0]] = wr_data;
    fill_d = clr ? '0 : fill_q + CW'(wr_en);
    idx_d  = clr ? '0 : idx_q + IW'(rd_adv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      fill_q <= '0;
      idx_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      fill_q <= fill_d;
      idx_q  <= idx_d;
    end
  end

  assign fill_cnt = fill_q;
  assign rd_data  = mem_q[idx_q];
  assign rd_last  = idx_q == IW'(BURST_LEN - 1);
endmodule

// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: drains the pixel queue into ping-pong frame buffers in
// external memory using burst writes; short frames are dropped, long ones truncated.
module frame_write_scheduler
  import frame_sched_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int ADDR_WIDTH  = 21,
  parameter int BUF_STRIDE  = 131072
) (
  input  logic                  MemClk,
  input  logic                  nRST,
  input  logic                  init_done,
  input  logic                  queue_empty,
  output logic                  queue_rd_en,
  input  logic [MARKER_BIT:0]   queue_rd_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [PIX_W-1:0]      mem_wr_data,
  output logic                  write_buf,
  output logic                  display_buf,
  output logic                  frame_done,
  output logic                  frame_drop,
  output logic                  frame_overrun,
  output logic [7:0]            drop_count
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  if (!cfg_ok(BURST_LEN, FRAME_WORDS, ADDR_WIDTH, BUF_STRIDE)) begin : g_bad_cfg
    $error("frame_write_scheduler: invalid BURST_LEN/FRAME_WORDS/ADDR_WIDTH/BUF_STRIDE");
  end

  state_e        state_q, state_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic          inflight_q, inflight_d;
  logic          write_buf_q, write_buf_d;
  logic          display_buf_q, display_buf_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_drop_q, frame_drop_d;
  logic          frame_overrun_q, frame_overrun_d;
  logic          ovr_seen_q, ovr_seen_d;
  logic [7:0]    drop_count_q, drop_count_d;

  logic          cap, mark, burst_end, rd_ok, buf_wr, buf_clr, rd_last;
  logic [CW-1:0] fill_cnt;
  logic [WW-1:0] word_next;

  // a captured word is the one requested on the previous cycle
  assign cap       = inflight_q;
  assign mark      = queue_rd_data[MARKER_BIT];
  assign burst_end = state_q == S_DATA && mem_wr_ready && rd_last;
  assign word_next = word_cnt_q + WW'(BURST_LEN);
  assign rd_ok     = state_q == S_WAIT_SYNC || state_q == S_DRAIN
                  || (state_q == S_FILL && fill_cnt + CW'(inflight_q) < CW'(BURST_LEN));
  assign queue_rd_en = !queue_empty && rd_ok;
  assign buf_wr    = cap && !mark && state_q == S_FILL;
  assign buf_clr   = burst_end || (cap && mark && state_q == S_FILL);

  burst_buffer #(.BURST_LEN(BURST_LEN)) u_buf (
    .clk     (MemClk),
    .rst_n   (nRST),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (queue_rd_data[PIX_W-1:0]),
    .rd_adv  (state_q == S_DATA && mem_wr_ready),
    .fill_cnt(fill_cnt),
    .rd_data (mem_wr_data),
    .rd_last (rd_last)
  );

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    inflight_d      = queue_rd_en;
    write_buf_d     = write_buf_q;
    display_buf_d   = display_buf_q;
    drop_count_d    = drop_count_q;
    ovr_seen_d      = ovr_seen_q;
    frame_done_d    = 1'b0;
    frame_drop_d    = 1'b0;
    frame_overrun_d = 1'b0;
    case (state_q)
      S_WAIT_INIT: state_d = init_done ? S_WAIT_SYNC : S_WAIT_INIT;
      S_WAIT_SYNC: if (cap && mark) begin
        state_d    = S_FILL;
        word_cnt_d = '0;
      end
      S_FILL: if (cap && mark) begin
        frame_drop_d = 1'b1;
        drop_count_d = drop_count_q + 8'(drop_count_q != 8'hff);
        word_cnt_d   = '0;
      end else if (cap && fill_cnt == CW'(BURST_LEN - 1)) begin
        state_d = S_CMD;
      end
      S_CMD: state_d = mem_cmd_ready ? S_DATA : S_CMD;
      S_DATA: if (burst_end) begin
        word_cnt_d = word_next;
        state_d    = word_next == WW'(FRAME_WORDS) ? S_COMPLETE : S_FILL;
      end
      S_COMPLETE: begin
        display_buf_d = write_buf_q;
        write_buf_d   = !write_buf_q;
        frame_done_d  = 1'b1;
        ovr_seen_d    = 1'b0;
        state_d       = S_DRAIN;
      end
      S_DRAIN: if (cap && mark) begin
        state_d    = S_FILL;
        word_cnt_d = '0;
      end else if (cap && !ovr_seen_q) begin
        frame_overrun_d = 1'b1;
        ovr_seen_d      = 1'b1;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge MemClk or negedge nRST) begin
    if (!nRST) begin
      state_q         <= S_WAIT_INIT;
      word_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      write_buf_q     <= 1'b0;
      display_buf_q   <= 1'b1;
      drop_count_q    <= '0;
      ovr_seen_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_drop_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      inflight_q      <= inflight_d;
      write_buf_q     <= write_buf_d;
      display_buf_q   <= display_buf_d;
      drop_count_q    <= drop_count_d;
      ovr_seen_q      <= ovr_seen_d;
      frame_done_q    <= frame_done_d;
      frame_drop_q    <= frame_drop_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign mem_cmd_valid = state_q == S_CMD;
  assign mem_wr_valid  = state_q == S_DATA;
  assign mem_cmd_addr  = (write_buf_q ? ADDR_WIDTH'(BUF_STRIDE) : '0) + ADDR_WIDTH'(word_cnt_q);
  assign write_buf     = write_buf_q;
  assign display_buf   = display_buf_q;
  assign frame_done    = frame_done_q;
  assign frame_drop    = frame_drop_q;
  assign frame_overrun = frame_overrun_q;
  assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_frame_write_scheduler.sv
// tb_frame_write_scheduler: table-driven frame scenarios plus randomized traffic,
// checked against a frame-level model of which bursts memory should receive.
module tb_frame_write_scheduler;
  localparam int BL = 8, FW = 32, AW = 21, STRIDE = 131072;

  logic          MemClk = 0, nRST = 1, init_done = 0, queue_empty = 1;
  logic          queue_rd_en;
  logic [16:0]   queue_rd_data = '0;
  logic          mem_cmd_valid, mem_cmd_ready = 1, mem_wr_valid, mem_wr_ready = 1;
  logic [AW-1:0] mem_cmd_addr;
  logic [15:0]   mem_wr_data;
  logic          write_buf, display_buf, frame_done, frame_drop, frame_overrun;
  logic [7:0]    drop_count;

  frame_write_scheduler #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_WIDTH(AW), .BUF_STRIDE(STRIDE)) dut (
    .MemClk(MemClk), .nRST(nRST), .init_done(init_done), .queue_empty(queue_empty),
    .queue_rd_en(queue_rd_en), .queue_rd_data(queue_rd_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .write_buf(write_buf), .display_buf(display_buf), .frame_done(frame_done),
    .frame_drop(frame_drop), .frame_overrun(frame_overrun), .drop_count(drop_count)
  );

  always #5 MemClk = ~MemClk;

  int n_checks = 0, n_fail = 0;
  logic [16:0] q[$];
  int dut_cmd[$], dut_data[$], exp_cmd[$], exp_data[$];
  int n_done = 0, n_drop = 0, n_ovr = 0, n_viol = 0, n_reads = 0, mode = 0, cmd_wait = 0;
  int ci = 0, di = 0;
  bit rd_pending = 0, prev_cmd_stall = 0, prev_wr_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  bit m_synced = 0, m_drain = 0, m_ov_seen = 0, m_wb = 0, m_db = 1;
  int m_cur[$];
  int m_done = 0, m_drops = 0, m_ovr = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Frame-level reference: collect pixels per frame, emit a burst for every BL pixels.
  function automatic void model_word(logic [16:0] w);
    if (!m_synced) begin
      if (w[16]) begin m_synced = 1; m_cur.delete(); end
      return;
    end
    if (m_drain) begin
      if (w[16]) begin m_drain = 0; m_cur.delete(); end
      else if (!m_ov_seen) begin m_ovr++; m_ov_seen = 1; end
      return;
    end
    if (w[16]) begin m_drops++; m_cur.delete(); return; end
    m_cur.push_back(int'(w[15:0]));
    if (m_cur.size() % BL == 0) begin
      exp_cmd.push_back((m_wb ? STRIDE : 0) + m_cur.size() - BL);
      for (int i = m_cur.size() - BL; i < m_cur.size(); i++) exp_data.push_back(m_cur[i]);
    end
    if (m_cur.size() == FW) begin
      m_done++; m_db = m_wb; m_wb = !m_wb; m_drain = 1; m_ov_seen = 0;
    end
  endfunction

  task automatic push(logic [16:0] w);
    q.push_back(w);
    model_word(w);
    queue_empty = 0;
  endtask

  task automatic step();
    @(negedge MemClk);
    if (queue_rd_en && q.size() == 0) n_viol++;
    if (queue_rd_en && (mem_cmd_valid || mem_wr_valid)) n_viol++;
    if (prev_cmd_stall && (!mem_cmd_valid || mem_cmd_addr != prev_addr)) n_viol++;
    if (prev_wr_stall && (!mem_wr_valid || mem_wr_data != prev_data)) n_viol++;
    prev_cmd_stall = mem_cmd_valid && !mem_cmd_ready;
    prev_addr      = mem_cmd_addr;
    prev_wr_stall  = mem_wr_valid && !mem_wr_ready;
    prev_data      = mem_wr_data;
    if (mem_cmd_valid && mem_cmd_ready) begin dut_cmd.push_back(int'(mem_cmd_addr)); cmd_wait = 0; end
    else if (mem_cmd_valid) cmd_wait++;
    if (mem_wr_valid && mem_wr_ready) dut_data.push_back(int'(mem_wr_data));
    n_done += int'(frame_done);
    n_drop += int'(frame_drop);
    n_ovr  += int'(frame_overrun);
    rd_pending = queue_rd_en;
    if (queue_rd_en) n_reads++;
    @(posedge MemClk);
    #1;
    if (rd_pending && q.size() > 0) queue_rd_data = q.pop_front();
    queue_empty = q.size() == 0;
    if (mode == 0) begin
      mem_cmd_ready = 1; mem_wr_ready = 1;
    end else if (mode == 1) begin
      mem_cmd_ready = cmd_wait >= 10; mem_wr_ready = !mem_wr_ready;
    end else begin
      mem_cmd_ready = $urandom_range(0, 3) != 0; mem_wr_ready = $urandom_range(0, 3) != 0;
    end
  endtask

  task automatic settle();
    int guard = 0;
    while (q.size() > 0 && guard < 3000) begin step(); guard++; end
    chk("queue_drained", q.size(), 0);
    repeat (80) step();
  endtask

  task automatic compare_all(string tag);
    chk({tag, " cmd_count"}, dut_cmd.size(), exp_cmd.size());
    chk({tag, " data_count"}, dut_data.size(), exp_data.size());
    for (int i = ci; i < exp_cmd.size() && i < dut_cmd.size(); i++) chk({tag, " cmd_addr"}, dut_cmd[i], exp_cmd[i]);
    for (int i = di; i < exp_data.size() && i < dut_data.size(); i++) chk({tag, " wr_data"}, dut_data[i], exp_data[i]);
    ci = exp_cmd.size();
    di = exp_data.size();
    chk({tag, " done_pulses"}, n_done, m_done);
    chk({tag, " drop_pulses"}, n_drop, m_drops);
    chk({tag, " overrun_pulses"}, n_ovr, m_ovr);
    chk({tag, " drop_count"}, drop_count, m_drops > 255 ? 255 : m_drops);
    chk({tag, " write_buf"}, write_buf, m_wb);
    chk({tag, " display_buf"}, display_buf, m_db);
    chk({tag, " protocol_violations"}, n_viol, 0);
  endtask

  typedef struct {
    int n_pix; int mode; int cmds; int done; int drop; int ovr; bit wb; bit db;
  } row_t;
  row_t rows[6];

  initial begin
    int c0, d0, dr0, o0, guard;
    rows[0] = '{32, 0, 4, 1, 0, 0, 1'b1, 1'b0};
    rows[1] = '{32, 0, 4, 1, 0, 0, 1'b0, 1'b1};
    rows[2] = '{12, 0, 1, 0, 0, 0, 1'b0, 1'b1};
    rows[3] = '{32, 0, 4, 1, 1, 0, 1'b1, 1'b0};
    rows[4] = '{40, 0, 4, 1, 0, 1, 1'b0, 1'b1};
    rows[5] = '{32, 1, 4, 1, 0, 0, 1'b1, 1'b0};

    #1 nRST = 0;
    repeat (2) step();
    chk("reset write_buf", write_buf, 0);
    chk("reset display_buf", display_buf, 1);
    chk("reset cmd_valid", mem_cmd_valid, 0);
    chk("reset wr_valid", mem_wr_valid, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset drop_count", drop_count, 0);
    chk("reset mem_cmd_addr", mem_cmd_addr, 0);
    nRST = 1;

    for (int i = 0; i < 5; i++) push(17'(100 + i));
    repeat (20) step();
    chk("no reads before init", n_reads, 0);
    init_done = 1;

    for (int r = 0; r < 6; r++) begin
      c0 = dut_cmd.size(); d0 = n_done; dr0 = n_drop; o0 = n_ovr;
      mode = rows[r].mode;
      push(17'h10000);
      for (int i = 0; i < rows[r].n_pix; i++) push(17'(r * 100 + i));
      settle();
      chk($sformatf("row%0d cmds", r), dut_cmd.size() - c0, rows[r].cmds);
      chk($sformatf("row%0d frame_done", r), n_done - d0, rows[r].done);
      chk($sformatf("row%0d frame_drop", r), n_drop - dr0, rows[r].drop);
      chk($sformatf("row%0d frame_overrun", r), n_ovr - o0, rows[r].ovr);
      chk($sformatf("row%0d write_buf", r), write_buf, rows[r].wb);
      chk($sformatf("row%0d display_buf", r), display_buf, rows[r].db);
      compare_all($sformatf("row%0d", r));
    end
    chk("pre-sync pixels read", n_reads >= 5, 1);

    mode = 2;
    for (int f = 0; f < 10; f++) begin
      int kind, n;
      kind = $urandom_range(0, 3);
      n = kind == 1 ? $urandom_range(0, FW - 1) : kind == 2 ? FW + $urandom_range(1, 12) : FW;
      push(17'h10000);
      for (int i = 0; i < n; i++) begin
        push(17'($urandom_range(0, 65535)));
        if ($urandom_range(0, 3) == 0) step();
      end
      settle();
      compare_all($sformatf("rand%0d", f));
    end

    mode = 0;
    repeat (260) push(17'h10000);
    settle();
    compare_all("saturate");
    chk("drop_count saturated", drop_count, 255);

    mode = 1;
    for (int i = 0; i < 8; i++) push(17'(500 + i));
    guard = 0;
    while (!mem_wr_valid && guard < 100) begin step(); guard++; end
    chk("reached data phase", mem_wr_valid, 1);
    #2 nRST = 0;
    #1;
    chk("midburst reset cmd_valid", mem_cmd_valid, 0);
    chk("midburst reset wr_valid", mem_wr_valid, 0);
    chk("midburst reset write_buf", write_buf, 0);
    chk("midburst reset display_buf", display_buf, 1);
    chk("midburst reset drop_count", drop_count, 0);
    prev_cmd_stall = 0; prev_wr_stall = 0;
    c0 = dut_cmd.size(); d0 = dut_data.size();
    repeat (3) step();
    nRST = 1;
    repeat (20) step();
    chk("no cmd after reset", dut_cmd.size() - c0, 0);
    chk("no data after reset", dut_data.size() - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
